piso_tx: RTL and testbench

//   Parallel-in serial-out transmitter: the stage directly upstream of the siso shift chain.
//   - Accepts a WIDTH-bit word on a valid/ready handshake.
//   - Serialises the word one bit per clk onto sout, which drives the siso d input.
//   - Inserts GAP idle cycles between words so downstream framing stays recoverable.

---
 rtl/piso_tx.sv | 127 ++++++++++++
 tb/tb_piso_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx -- parallel-in serial-out transmitter feeding the siso shift chain.
//   Accepts a WIDTH-bit word on a valid/ready handshake, shifts it out one bit
//   per clock on sout, then idles GAP cycles (sout=0) so framing is recoverable.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_data    parallel word, sampled only on accept
//   in_valid   producer offers in_data
//   in_ready   block can accept (accept = in_valid & in_ready at posedge clk)
//   sout       serial data to siso d
//   sout_valid sout carries a payload bit
//   busy       registered SHIFT/GAP indication, aligned with sout
//   done       one-cycle pulse coincident with the last payload bit
module piso_tx #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned GAP       = 1,
   parameter int unsigned LSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned    CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);
   localparam logic [3:0]     GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CW-1:0]    bit_cnt, bit_cnt_n;
   logic [3:0]       gap_cnt, gap_cnt_n;
   logic             sout_n, sout_valid_n, done_n;
   logic             last_bit, accept, cur_bit;

   assign last_bit = (state == ST_SHIFT) && (bit_cnt == '0);
   // With GAP=0 the next word is taken during the last shift cycle so the
   // serial stream has no bubble between words.
   assign in_ready = !rst && ((state == ST_IDLE) || ((GAP == 0) && last_bit));
   assign accept   = in_valid && in_ready;
   assign cur_bit  = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];

   always_comb begin
      state_n      = state;
      shreg_n      = shreg;
      bit_cnt_n    = bit_cnt;
      gap_cnt_n    = gap_cnt;
      sout_n       = 1'b0;
      sout_valid_n = 1'b0;
      done_n       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_n   = ST_SHIFT;
               shreg_n   = in_data;
               bit_cnt_n = CNT_LOAD;
            end
         end
         ST_SHIFT: begin
            sout_n       = cur_bit;
            sout_valid_n = 1'b1;
            shreg_n      = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
            bit_cnt_n    = bit_cnt - 1'b1;
            if (last_bit) begin
               done_n = 1'b1;
               if (GAP > 0) begin
                  state_n   = ST_GAP;
                  gap_cnt_n = GAP_LOAD;
                  bit_cnt_n = '0;
               end else if (accept) begin
                  shreg_n   = in_data;
                  bit_cnt_n = CNT_LOAD;
               end else begin
                  state_n   = ST_IDLE;
                  bit_cnt_n = '0;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == '0) begin
               state_n = ST_IDLE;
            end else begin
               gap_cnt_n = gap_cnt - 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         shreg      <= shreg_n;
         bit_cnt    <= bit_cnt_n;
         gap_cnt    <= gap_cnt_n;
         sout       <= sout_n;
         sout_valid <= sout_valid_n;
         // busy reflects the state that produced the current sout, so it
         // stays aligned with the serial output rather than the FSM.
         busy       <= (state != ST_IDLE);
         done       <= done_n;
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx -- directed bench for piso_tx.
//   u_a: WIDTH=4 GAP=1 MSB first; u_b: LSB first; u_c: GAP=0 streaming.
//   A 4-stage siso model hangs off u_b's sout.
module tb_piso_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a_data, b_data, c_data;
   logic       a_valid, b_valid, c_valid;
   logic       a_ready, b_ready, c_ready;
   logic       a_sout, b_sout, c_sout;
   logic       a_sv, b_sv, c_sv;
   logic       a_busy, b_busy, c_busy;
   logic       a_done, b_done, c_done;
   logic [3:0] siso;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   piso_tx #(.WIDTH(4), .GAP(1), .LSB_FIRST(0)) u_a (
      .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
      .sout(a_sout), .sout_valid(a_sv), .busy(a_busy), .done(a_done));

   piso_tx #(.WIDTH(4), .GAP(1), .LSB_FIRST(1)) u_b (
      .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
      .sout(b_sout), .sout_valid(b_sv), .busy(b_busy), .done(b_done));

   piso_tx #(.WIDTH(4), .GAP(0), .LSB_FIRST(0)) u_c (
      .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
      .sout(c_sout), .sout_valid(c_sv), .busy(c_busy), .done(c_done));

   // downstream siso chain: out is siso[3]
   always @(posedge clk) begin
      if (rst) siso <= '0;
      else     siso <= {siso[2:0], b_sout};
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; a_valid = 1'b1; a_data = 4'hF;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", a_ready); end
         checks++; if (a_sout !== 1'b0 || a_sv !== 1'b0) begin errors++; $display("FAIL reset_sout got %b/%b exp 0/0", a_sout, a_sv); end
         checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b exp 0/0", a_busy, a_done); end
      end
      rst = 1'b0;
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", a_ready); end
      a_valid = 1'b0;
      tick();
      checks++; if (a_busy !== 1'b0 || a_sv !== 1'b0) begin errors++; $display("FAIL reset_no_accept got %b/%b exp 0/0", a_busy, a_sv); end
   endtask

   task automatic test_msb_gap;
      logic [3:0] w;
      w = 4'b1011;
      a_valid = 1'b1; a_data = w;
      tick();                               // edge N: accept
      a_valid = 1'b0; a_data = 4'h0;
      checks++; if (a_sv !== 1'b0) begin errors++; $display("FAIL msb_n_valid got %b exp 0", a_sv); end
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if (a_sout !== w[4-i] || a_sv !== 1'b1) begin errors++; $display("FAIL msb_bit%0d got %b/%b exp %b/1", i, a_sout, a_sv, w[4-i]); end
         checks++; if (a_done !== (i == 4)) begin errors++; $display("FAIL msb_done%0d got %b exp %b", i, a_done, (i == 4)); end
         checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL msb_busy%0d got %b exp 1", i, a_busy); end
      end
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL msb_gap_ready got %b exp 0", a_ready); end
      tick();                               // N+5: gap on the wire
      checks++; if (a_sout !== 1'b0 || a_sv !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL msb_gap_out got %b/%b/%b exp 0/0/0", a_sout, a_sv, a_done); end
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL msb_gap_busy got %b exp 1", a_busy); end
      // ready again so the next accept lands on edge N+6
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL msb_ready_again got %b exp 1", a_ready); end
      tick();
      checks++; if (a_busy !== 1'b0 || a_sv !== 1'b0) begin errors++; $display("FAIL msb_idle got %b/%b exp 0/0", a_busy, a_sv); end
   endtask

   task automatic test_lsb_siso;
      b_valid = 1'b1; b_data = 4'b1000;
      tick();                               // edge N
      b_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if (b_sout !== (i == 4) || b_sv !== 1'b1) begin errors++; $display("FAIL lsb_bit%0d got %b/%b exp %b/1", i, b_sout, b_sv, (i == 4)); end
      end
      for (int i = 5; i <= 8; i++) begin
         tick();
         checks++; if (siso[3] !== (i == 8)) begin errors++; $display("FAIL lsb_siso_n%0d got %b exp %b", i, siso[3], (i == 8)); end
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp;
      exp = 8'b1010_0101;
      c_valid = 1'b1; c_data = 4'hA;
      tick();                               // edge N: accept A
      c_data = 4'h5;
      checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_mid got %b exp 0", c_ready); end
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 3) begin
            checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_last got %b exp 1", c_ready); end
         end
         if (i == 4) c_valid = 1'b0;
         checks++; if (c_sout !== exp[8-i] || c_sv !== 1'b1) begin errors++; $display("FAIL b2b_bit%0d got %b/%b exp %b/1", i, c_sout, c_sv, exp[8-i]); end
         checks++; if (c_done !== (i == 4 || i == 8)) begin errors++; $display("FAIL b2b_done%0d got %b exp %b", i, c_done, (i == 4 || i == 8)); end
      end
      tick();
      checks++; if (c_sv !== 1'b0 || c_sout !== 1'b0) begin errors++; $display("FAIL b2b_end got %b/%b exp 0/0", c_sv, c_sout); end
   endtask

   task automatic test_mid_reset;
      logic [3:0] w;
      a_valid = 1'b1; a_data = 4'hF;
      tick();
      a_valid = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         tick();
         checks++; if (a_sout !== 1'b1 || a_sv !== 1'b1) begin errors++; $display("FAIL midrst_bit%0d got %b/%b exp 1/1", i, a_sout, a_sv); end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (a_sout !== 1'b0 || a_sv !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL midrst_clear got %b/%b/%b exp 0/0/0", a_sout, a_sv, a_done); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (a_sv !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL midrst_quiet%0d got %b/%b exp 0/0", i, a_sv, a_done); end
      end
      w = 4'b0110;
      a_valid = 1'b1; a_data = w;
      tick();
      a_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if (a_sout !== w[4-i] || a_sv !== 1'b1 || a_done !== (i == 4)) begin errors++; $display("FAIL midrst_next%0d got %b/%b/%b exp %b/1/%b", i, a_sout, a_sv, a_done, w[4-i], (i == 4)); end
      end
      tick(); tick();
   endtask

   task automatic test_backpressure;
      logic [3:0] w1, w2;
      w1 = 4'b1100; w2 = 4'b0110;
      a_valid = 1'b1; a_data = w1;
      tick();                               // edge N: accept w1
      a_data = 4'b0011;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 2) a_data = 4'b0101;
         if (i == 3) a_data = w2;
         checks++; if (a_sout !== w1[4-i] || a_sv !== 1'b1) begin errors++; $display("FAIL bp_bit%0d got %b/%b exp %b/1", i, a_sout, a_sv, w1[4-i]); end
         checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b exp 0", i, a_ready); end
      end
      tick();                               // N+5
      checks++; if (a_ready !== 1'b1 || a_sv !== 1'b0) begin errors++; $display("FAIL bp_gap got %b/%b exp 1/0", a_ready, a_sv); end
      tick();                               // N+6: w2 accepted
      a_valid = 1'b0;
      checks++; if (a_sv !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", a_sv); end
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if (a_sout !== w2[4-i] || a_sv !== 1'b1 || a_done !== (i == 4)) begin errors++; $display("FAIL bp_next%0d got %b/%b/%b exp %b/1/%b", i, a_sout, a_sv, a_done, w2[4-i], (i == 4)); end
      end
      tick(); tick();
   endtask

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
      a_data = '0; b_data = '0; c_data = '0;
      test_reset();
      test_msb_gap();
      test_lsb_siso();
      test_back_to_back();
      test_mid_reset();
      test_backpressure();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
